// File: rtl/alu_pkg.sv
// Shared opcode constants, legality check and requester-ID type for the ALU share arbiter.
package alu_pkg;

  localparam int unsigned ALU_OPW = 4;

  localparam logic [ALU_OPW-1:0] ALU_AND = 4'b0000;
  localparam logic [ALU_OPW-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALU_OPW-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALU_OPW-1:0] ALU_SUB = 4'b0110;

  typedef logic alu_req_id_t;

  function automatic logic alu_op_legal(input logic [ALU_OPW-1:0] op);
    return (op == ALU_AND) || (op == ALU_OR) || (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/alu_share_arb_if.sv
// Request, ALU-side and response signals of the shared-ALU arbiter.
interface alu_share_arb_if #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
);
  logic            req0_valid;
  logic            req0_ready;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic [OPW-1:0]  req0_op;
  logic            req1_valid;
  logic            req1_ready;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic [OPW-1:0]  req1_op;
  logic [XLEN-1:0] alu_a;
  logic [XLEN-1:0] alu_b;
  logic [OPW-1:0]  alu_control;
  logic [XLEN-1:0] alu_result;
  logic            alu_zero;
  logic            rsp_valid;
  logic            rsp_ready;
  logic [XLEN-1:0] rsp_result;
  logic            rsp_zero;
  logic            rsp_id;
  logic            rsp_err;

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready, alu_a, alu_b, alu_control,
    output rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err
  );

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready, alu_a, alu_b, alu_control,
    input  rsp_valid, rsp_result, rsp_zero, rsp_id, rsp_err
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-way arbiter: round-robin on last_id, or fixed priority to requester 0
// when ALU_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        valid0,
  input  logic        valid1,
  input  logic        advance,
  output logic [1:0]  grant_c,
  output alu_req_id_t last_id
);

  always_comb begin
    grant_c = 2'b00;
    if (valid0 && valid1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      grant_c = 2'b01;
`else
      grant_c = last_id ? 2'b01 : 2'b10;
`endif
    end else if (valid0) begin
      grant_c = 2'b01;
    end else if (valid1) begin
      grant_c = 2'b10;
    end
  end

`ifdef ALU_ARB_FIXED_PRIO_EN
  logic unused_fixed;
  assign unused_fixed = ^{clk, rst_n, advance};
  assign last_id      = 1'b1;
`else
  // Only an accepted handshake moves the round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_id <= 1'b1;
    end else if (advance && (grant_c != 2'b00)) begin
      last_id <= grant_c[1];
    end
  end
`endif

endmodule

// File: rtl/alu_share_arb.sv
// Two-requester arbiter with operand (S1) and response (S2) stages around an external ALU.
// Optional build macro: ALU_ARB_FIXED_PRIO_EN (requester 0 always wins ties).
module alu_share_arb
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32,
  parameter int unsigned OPW  = 4
) (
  input logic            clk,
  input logic            rst_n,
  alu_share_arb_if.slave bus
);

  logic            s1_v;
  logic [XLEN-1:0] s1_a;
  logic [XLEN-1:0] s1_b;
  logic [OPW-1:0]  s1_op;
  alu_req_id_t     s1_id;
  logic            s1_err;

  logic            s2_v;
  logic [XLEN-1:0] s2_result;
  logic            s2_zero;
  alu_req_id_t     s2_id;
  logic            s2_err;

  logic            s1_adv;
  logic            s2_adv;
  logic            accept;
  logic [1:0]      grant_c;
  alu_req_id_t     last_id_unused;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic [OPW-1:0]  in_op;

  assign s2_adv = !s2_v || bus.rsp_ready;
  assign s1_adv = !s1_v || s2_adv;
  assign accept = s1_adv && (grant_c != 2'b00);

  rr_arbiter2 u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid0  (bus.req0_valid),
    .valid1  (bus.req1_valid),
    .advance (s1_adv),
    .grant_c (grant_c),
    .last_id (last_id_unused)
  );

  assign bus.req0_ready = s1_adv && grant_c[0];
  assign bus.req1_ready = s1_adv && grant_c[1];

  assign in_a  = grant_c[1] ? bus.req1_a  : bus.req0_a;
  assign in_b  = grant_c[1] ? bus.req1_b  : bus.req0_b;
  assign in_op = grant_c[1] ? bus.req1_op : bus.req0_op;

  // Operand stage: payload only reloads on an accepted request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v   <= 1'b0;
      s1_a   <= '0;
      s1_b   <= '0;
      s1_op  <= '0;
      s1_id  <= 1'b0;
      s1_err <= 1'b0;
    end else if (s1_adv) begin
      s1_v <= accept;
      if (accept) begin
        s1_a   <= in_a;
        s1_b   <= in_b;
        s1_op  <= in_op;
        s1_id  <= grant_c[1];
        s1_err <= !alu_op_legal(ALU_OPW'(in_op));
      end
    end
  end

  // Response stage: holds while rsp_valid and not rsp_ready.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_v      <= 1'b0;
      s2_result <= '0;
      s2_zero   <= 1'b0;
      s2_id     <= 1'b0;
      s2_err    <= 1'b0;
    end else if (s2_adv) begin
      s2_v <= s1_v;
      if (s1_v) begin
        s2_result <= bus.alu_result;
        s2_zero   <= bus.alu_zero;
        s2_id     <= s1_id;
        s2_err    <= s1_err;
      end
    end
  end

  assign bus.alu_a       = s1_a;
  assign bus.alu_b       = s1_b;
  assign bus.alu_control = s1_op;
  assign bus.rsp_valid   = s2_v;
  assign bus.rsp_result  = s2_result;
  assign bus.rsp_zero    = s2_zero;
  assign bus.rsp_id      = s2_id;
  assign bus.rsp_err     = s2_err;

endmodule

// File: tb/tb_alu_share_arb.sv
// Directed self-checking bench for alu_share_arb with a behavioural external ALU.
module tb_alu_share_arb;
  import alu_pkg::*;

  logic clk;
  logic rst_n;
  int   nvec;
  int   nmis;

  alu_share_arb_if bus ();

  alu_share_arb dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External ALU model; unsupported codes return a ^ b.
  always_comb begin
    case (bus.alu_control)
      ALU_AND: bus.alu_result = bus.alu_a & bus.alu_b;
      ALU_OR:  bus.alu_result = bus.alu_a | bus.alu_b;
      ALU_ADD: bus.alu_result = bus.alu_a + bus.alu_b;
      ALU_SUB: bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = bus.alu_a ^ bus.alu_b;
    endcase
    bus.alu_zero = (bus.alu_result == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nmis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk_rsp(input string tag, input logic [31:0] res, input logic zero,
                         input logic id, input logic err);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    chk({tag, "_result"}, bus.rsp_result, res);
    chk({tag, "_zero"}, 32'(bus.rsp_zero), 32'(zero));
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'(id));
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'(err));
  endtask

  function automatic logic exp_id(input int k);
`ifdef ALU_ARB_FIXED_PRIO_EN
    return 1'b0;
`else
    return 1'(k % 2);
`endif
  endfunction

  function automatic logic [31:0] exp_res(input logic id);
    return id ? 32'd7 : 32'd15;
  endfunction

  initial begin
    nvec = 0;
    nmis = 0;
    rst_n = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_a = 32'd10; bus.req0_b = 32'd5; bus.req0_op = ALU_ADD;
    bus.req1_valid = 1'b0; bus.req1_a = 32'd0;  bus.req1_b = 32'd0; bus.req1_op = ALU_AND;

    // Reset state
    cyc(); cyc(); #1;
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_alu_a", bus.alu_a, 32'd0);
    chk("rst_alu_ctl", 32'(bus.alu_control), 32'd0);
    chk("rst_rsp_result", bus.rsp_result, 32'd0);
    chk("rst_rsp_flags", 32'({bus.rsp_zero, bus.rsp_id, bus.rsp_err}), 32'd0);
    chk("rst_readies", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
    rst_n = 1'b1;

    // Single ADD from requester 0
    cyc();
    bus.req0_valid = 1'b0;
    chk("add_alu_a", bus.alu_a, 32'd10);
    chk("add_alu_b", bus.alu_b, 32'd5);
    chk("add_alu_ctl", 32'(bus.alu_control), 32'(ALU_ADD));
    chk("add_early_valid", 32'(bus.rsp_valid), 32'd0);

    // Requester 1: SUB 5,5 then AND 10,5 back-to-back
    bus.req1_valid = 1'b1; bus.req1_a = 32'd5; bus.req1_b = 32'd5; bus.req1_op = ALU_SUB;
    #1 chk("sub_ready", 32'(bus.req1_ready), 32'd1);
    cyc();
    chk_rsp("add_rsp", 32'h0000000F, 1'b0, 1'b0, 1'b0);
    bus.req1_a = 32'd10; bus.req1_op = ALU_AND;
    #1 chk("and_ready", 32'(bus.req1_ready), 32'd1);
    cyc();
    bus.req1_valid = 1'b0;
    chk_rsp("sub_rsp", 32'h0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_rsp("and_rsp", 32'h0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk("drain_valid", 32'(bus.rsp_valid), 32'd0);

    // Both requesters valid for six accepts
    bus.req0_valid = 1'b1; bus.req0_a = 32'd7; bus.req0_b = 32'd8; bus.req0_op = ALU_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd3; bus.req1_b = 32'd4; bus.req1_op = ALU_OR;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk("tie_grant", 32'({bus.req1_ready, bus.req0_ready}), exp_id(i) ? 32'b10 : 32'b01);
      if (i >= 2) begin
        chk("tie_rsp_id", 32'(bus.rsp_id), 32'(exp_id(i - 2)));
        chk("tie_rsp_result", bus.rsp_result, exp_res(exp_id(i - 2)));
      end
      cyc();
    end

    // Backpressure with both stages full
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_readies", 32'({bus.req1_ready, bus.req0_ready}), 32'b00);
      chk("bp_rsp_id", 32'(bus.rsp_id), 32'(exp_id(4)));
      chk("bp_rsp_result", bus.rsp_result, exp_res(exp_id(4)));
      chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
      cyc();
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    bus.rsp_ready  = 1'b1;
    chk_rsp("bp_rel0", exp_res(exp_id(4)), 1'b0, exp_id(4), 1'b0);
    cyc();
    chk_rsp("bp_rel1", exp_res(exp_id(5)), 1'b0, exp_id(5), 1'b0);
    cyc();
    chk("bp_drain", 32'(bus.rsp_valid), 32'd0);

    // Unsupported opcode
    bus.req0_valid = 1'b1; bus.req0_a = 32'd3; bus.req0_b = 32'd2; bus.req0_op = 4'b1111;
    #1 chk("err_ready", 32'(bus.req0_ready), 32'd1);
    cyc();
    bus.req0_valid = 1'b0;
    chk("err_alu_ctl", 32'(bus.alu_control), 32'hF);
    chk("err_alu_a", bus.alu_a, 32'd3);
    cyc();
    chk_rsp("err_rsp", 32'h1, 1'b0, 1'b0, 1'b1);

    // Reset while both stages are full
    bus.req0_valid = 1'b1; bus.req0_a = 32'd1; bus.req0_b = 32'd1; bus.req0_op = ALU_ADD;
    cyc();
    bus.req0_a = 32'd2; bus.req0_b = 32'd2;
    cyc();
    bus.req0_valid = 1'b0;
    bus.rsp_ready  = 1'b0;
    chk("mid_rsp_result", bus.rsp_result, 32'd2);
    chk("mid_alu_a", bus.alu_a, 32'd2);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mid_rst_alu_a", bus.alu_a, 32'd0);
    bus.req0_valid = 1'b1; bus.req0_a = 32'd9; bus.req0_b = 32'd9; bus.req0_op = ALU_ADD;
    bus.req1_valid = 1'b1; bus.req1_a = 32'd1; bus.req1_b = 32'd2; bus.req1_op = ALU_OR;
    cyc();
    rst_n = 1'b1;
    bus.rsp_ready = 1'b1;
    #1 chk("post_rst_tie", 32'({bus.req1_ready, bus.req0_ready}), 32'b01);
    cyc();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    chk("post_rst_alu_a", bus.alu_a, 32'd9);
    cyc();
    chk_rsp("post_rst_rsp", 32'd18, 1'b0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
